maxpool_b_unit: RTL

//   Streaming 2x2 / stride-2 max-pool stage sitting directly downstream of the conv-B unit.

---
 rtl/maxpool_b_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/maxpool_b_unit.sv
// Streaming 2x2 / stride-2 max-pool stage for IEEE-754 single pixels, fed in raster order by conv-B.
// Optional MAXPOOL_FUSED_RELU_EN clamps negative pooled results to +0 at the output register.
module maxpool_b_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int IFM_SIZE   = 10,
    parameter int OFM_SIZE   = IFM_SIZE / 2,
    parameter int COL_BITS   = $clog2(IFM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pool_clear,
    input  logic                  pool_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] pool_data_out,
    output logic                  pool_valid,
    output logic                  frame_done
);

    localparam int LB_BITS = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
    localparam logic [COL_BITS-1:0] LAST = COL_BITS'(IFM_SIZE - 1);

    // Keeps the first (stored) operand unless the second is strictly greater in IEEE order.
    function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] first,
                                                     input logic [DATA_WIDTH-1:0] second);
        logic                  sign_f;
        logic                  sign_s;
        logic [DATA_WIDTH-2:0] mag_f;
        logic [DATA_WIDTH-2:0] mag_s;
        logic                  take;
        sign_f = first[DATA_WIDTH-1];
        sign_s = second[DATA_WIDTH-1];
        mag_f  = first[DATA_WIDTH-2:0];
        mag_s  = second[DATA_WIDTH-2:0];
        if (sign_f != sign_s)
            take = !sign_s && !((mag_f == '0) && (mag_s == '0));
        else if (!sign_f)
            take = mag_s > mag_f;
        else
            take = mag_s < mag_f;
        return take ? second : first;
    endfunction

    logic [COL_BITS-1:0]   col;
    logic [COL_BITS-1:0]   row;
    logic [DATA_WIDTH-1:0] part;
    logic [DATA_WIDTH-1:0] lbuf [OFM_SIZE];
    logic [LB_BITS-1:0]    lb_idx;
    logic [DATA_WIDTH-1:0] lbuf_rd;
    logic [DATA_WIDTH-1:0] pmax;
    logic [DATA_WIDTH-1:0] out_val;
    logic                  accept;

    assign accept  = pool_enable && !pool_clear;
    assign lb_idx  = LB_BITS'(col >> 1);
    assign lbuf_rd = lbuf[lb_idx];
    assign pmax    = fp_max(part, data_in);

`ifdef MAXPOOL_FUSED_RELU_EN
    assign out_val = pmax[DATA_WIDTH-1] ? '0 : pmax;
`else
    assign out_val = pmax;
`endif

    // Line buffer is always written on an even row before the odd row reads it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept && !row[0] && col[0])
            lbuf[lb_idx] <= pmax;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col           <= '0;
            row           <= '0;
            part          <= '0;
            pool_data_out <= '0;
            pool_valid    <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            pool_valid <= 1'b0;
            frame_done <= 1'b0;
            if (pool_clear) begin
                col  <= '0;
                row  <= '0;
                part <= '0;
            end else if (pool_enable) begin
                case ({row[0], col[0]})
                    2'b00: part <= data_in;
                    2'b01: ;
                    2'b10: part <= fp_max(lbuf_rd, data_in);
                    2'b11: begin
                        pool_data_out <= out_val;
                        pool_valid    <= 1'b1;
                        frame_done    <= (row == LAST) && (col == LAST);
                    end
                endcase
                if (col == LAST) begin
                    col <= '0;
                    row <= (row == LAST) ? '0 : row + COL_BITS'(1);
                end else begin
                    col <= col + COL_BITS'(1);
                end
            end
        end
    end

endmodule
